sram_operand_reader: RTL and testbench
======================================

SRAM_OPERAND_READER -- requirements
Module: sram_operand_reader

Interface
REQ-001 SHALL have parameter P_ADDR_LEN, default 16'd10, SRAM address width.
REQ-002 SHALL have parameter P_BITDEPTH, default 16'd16, SRAM word width.
REQ-003 SHALL have port i_clk  input  1  single clock for all logic.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle burst request.
REQ-006 SHALL have port i_base_addr  input  P_ADDR_LEN  first word address.
REQ-007 SHALL have port i_count  input  P_ADDR_LEN+1  number of words to read.
REQ-008 SHALL have port o_busy  output  1  burst in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse at burst end.
REQ-010 SHALL have port o_rden  output  1  SRAM read enable.
REQ-011 SHALL have port o_rdaddr  output  P_ADDR_LEN  SRAM read address.
REQ-012 SHALL have port i_rddata  input  P_BITDEPTH  SRAM read data, valid one cycle after o_rden.
REQ-013 SHALL have port o_valid  output  1  stream word valid.
REQ-014 SHALL have port i_ready  input  1  downstream (divider) accepts word.
REQ-015 SHALL have port o_data  output  P_BITDEPTH  stream word.
REQ-016 SHALL have port o_last  output  1  marks final word of burst, qualified by o_valid.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: i_start=1 with i_count!=0 SHALL latch base address and count, go RUN; i_start with i_count=0 SHALL go DONE, no reads issued.
REQ-019 i_start outside IDLE SHALL be ignored.
REQ-020 RUN: o_rden SHALL be 1 when credit exists, credit = (reads in flight + buffered words) < 2; o_rdaddr SHALL be the current address at that cycle.
REQ-021 Each issued read SHALL increment the address modulo 2**P_ADDR_LEN (wrap from all-ones to 0) and decrement remaining-issue count.
REQ-022 After the last read is issued, FSM SHALL go DRAIN; o_rden SHALL stay 0 until the next burst.
REQ-023 i_rddata SHALL be captured into a 2-entry FIFO on the cycle after o_rden=1; the FIFO SHALL never overflow.
REQ-024 o_valid = FIFO not empty; o_data = FIFO head; transfer occurs when o_valid & i_ready; o_data SHALL stay stable while o_valid & !i_ready.
REQ-025 Simultaneous capture and transfer on the same cycle SHALL keep FIFO occupancy unchanged.
REQ-026 o_last SHALL be 1 exactly on the word numbered i_count (1-based) of the burst.
REQ-027 DRAIN: on transfer of the o_last word, FSM SHALL go DONE; DONE SHALL assert o_done for one cycle and return to IDLE.
REQ-028 o_busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-029 Latency: with i_ready held 1, i_start sampled at edge N -> o_rden high cycle N..N+1, first o_valid after edge N+2, then one word per cycle.
REQ-030 i_count = 2**P_ADDR_LEN SHALL read every address exactly once, wrapping as required.

Reset
REQ-031 i_rst=1 SHALL asynchronously force IDLE, FIFO empty, in-flight flag clear, address and counts 0.
REQ-032 During and after reset until next burst: o_busy=0, o_done=0, o_rden=0, o_rdaddr=0, o_valid=0, o_last=0, o_data=0.
REQ-033 Reset asserted mid-burst SHALL discard pending and in-flight words; no o_done is issued for the aborted burst.

Verification
REQ-034 Base 0x010, count 4, SRAM[a]=a, i_ready=1 -> o_data 0x010..0x013 on consecutive cycles, o_last on 0x013, o_done one cycle after.
REQ-035 Base 0x3FE, count 4 -> o_rdaddr sequence 0x3FE,0x3FF,0x000,0x001; data in same order.
REQ-036 Count 8, i_ready toggled pseudo-randomly -> all 8 words in order, no loss or duplication, o_data stable while stalled, o_rden never issued with credit exhausted.
REQ-037 Count 0 -> no o_rden, no o_valid, o_done one cycle after start; second i_start during busy burst ignored.
REQ-038 Count 6, i_rst pulsed after 3rd transfer -> all outputs 0 asynchronously; subsequent burst base 0x020 count 2 completes normally.

Source files
------------

// File: rtl/sram_operand_reader.sv
// sram_operand_reader
// Reads a burst of consecutive words from a synchronous SRAM (one-cycle read
// latency) and presents them as a valid/ready stream to a downstream consumer.
// A two-entry skid FIFO absorbs read data while the consumer stalls. Reads are
// only issued when the FIFO is guaranteed to have room for the returning word.
//
// Ports
//   i_clk        clock for all logic
//   i_rst        asynchronous active-high reset
//   i_start      one-cycle burst request (ignored unless idle)
//   i_base_addr  first SRAM word address of the burst
//   i_count      number of words to read (0 .. 2**P_ADDR_LEN)
//   o_busy       burst in progress (RUN or DRAIN)
//   o_done       one-cycle pulse after the final word has been accepted
//   o_rden       SRAM read enable
//   o_rdaddr     SRAM read address
//   i_rddata     SRAM read data, valid the cycle after o_rden
//   o_valid      stream word valid
//   i_ready      downstream accepts the word
//   o_data       stream word (zero while nothing is buffered)
//   o_last       final word of the burst, qualified by o_valid
module sram_operand_reader #(
   parameter int unsigned P_ADDR_LEN = 16'd10,
   parameter int unsigned P_BITDEPTH = 16'd16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [P_ADDR_LEN-1:0] i_base_addr,
   input  logic [P_ADDR_LEN:0]   i_count,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_rden,
   output logic [P_ADDR_LEN-1:0] o_rdaddr,
   input  logic [P_BITDEPTH-1:0] i_rddata,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [P_BITDEPTH-1:0] o_data,
   output logic                  o_last
);

   localparam logic [P_ADDR_LEN-1:0] ADDR_ONE = {{(P_ADDR_LEN-1){1'b0}}, 1'b1};
   localparam logic [P_ADDR_LEN:0]   CNT_ONE  = {{P_ADDR_LEN{1'b0}}, 1'b1};
   localparam logic [P_ADDR_LEN:0]   CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [P_ADDR_LEN-1:0]   addr;
   logic [P_ADDR_LEN:0]     issue_left;
   logic [P_ADDR_LEN:0]     xfer_left;
   logic                    inflight;
   logic [1:0]              occ;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [P_BITDEPTH-1:0]   fifo_mem [2];
   logic                    xfer;
   logic [1:0]              pending;
   logic                    launch;

   // A word leaving the FIFO this cycle frees its slot at the same edge, so it
   // is not counted against the credit; this sustains one word per cycle.
   always_comb begin
      xfer     = o_valid & i_ready;
      pending  = occ + {1'b0, inflight} - {1'b0, xfer};
      launch   = (state == IDLE) & i_start & (i_count != CNT_ZERO);
      o_valid  = (occ != 2'd0);
      o_data   = o_valid ? fifo_mem[rd_ptr] : '0;
      o_last   = o_valid & (xfer_left == CNT_ONE);
      o_rden   = (state == RUN) & ~pending[1];
      o_rdaddr = addr;
      o_busy   = (state == RUN) | (state == DRAIN);
      o_done   = (state == DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = (i_count != CNT_ZERO) ? RUN : DONE;
            end
         end
         RUN: begin
            if (o_rden && (issue_left == CNT_ONE)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (xfer && o_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr       <= '0;
         issue_left <= '0;
         xfer_left  <= '0;
         inflight   <= 1'b0;
         occ        <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
      end else begin
         if (launch) begin
            addr       <= i_base_addr;
            issue_left <= i_count;
            xfer_left  <= i_count;
         end else begin
            if (o_rden) begin
               addr       <= addr + ADDR_ONE;
               issue_left <= issue_left - CNT_ONE;
            end
            if (xfer) begin
               xfer_left <= xfer_left - CNT_ONE;
            end
         end
         inflight <= o_rden;
         occ      <= pending;
         if (inflight) begin
            wr_ptr <= ~wr_ptr;
         end
         if (xfer) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Storage needs no reset: o_data is masked to zero whenever the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (inflight) begin
         fifo_mem[wr_ptr] <= i_rddata;
      end
   end

endmodule

// File: tb/tb_sram_operand_reader.sv
// Testbench for sram_operand_reader: SRAM model with one-cycle read latency,
// scoreboard queues for expected read addresses and stream words, a negedge
// monitor, and a linear sequence of directed bursts.
module tb_sram_operand_reader;

   localparam int AW = 10;
   localparam int DW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_base_addr = '0;
   logic [AW:0]   i_count = '0;
   logic          o_busy;
   logic          o_done;
   logic          o_rden;
   logic [AW-1:0] o_rdaddr;
   logic [DW-1:0] i_rddata;
   logic          o_valid;
   logic          i_ready = 1'b1;
   logic [DW-1:0] o_data;
   logic          o_last;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] sram_q = '0;

   int   errors = 0;
   int   checks = 0;
   int   xfer_cnt = 0;
   logic [AW-1:0] addr_q [$];
   exp_t          exp_q [$];

   // monitor state
   int            m_occ = 0;
   int            m_infl = 0;
   bit            stall_prev = 0;
   logic [DW-1:0] stall_data = '0;
   bit            mon_xfer;
   logic [AW-1:0] mon_a;
   exp_t          mon_e;

   sram_operand_reader #(.P_ADDR_LEN(AW), .P_BITDEPTH(DW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
      .i_base_addr(i_base_addr), .i_count(i_count),
      .o_busy(o_busy), .o_done(o_done), .o_rden(o_rden), .o_rdaddr(o_rdaddr),
      .i_rddata(i_rddata), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_last(o_last)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) if (o_rden) sram_q <= mem[o_rdaddr];
   assign i_rddata = sram_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (i_rst) begin
         m_occ = 0;
         m_infl = 0;
         stall_prev = 0;
      end else begin
         mon_xfer = o_valid && i_ready;
         if (stall_prev) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", o_data, stall_data);
         end
         chk("valid_vs_fifo", o_valid, (m_occ != 0));
         chk("fifo_bound", (m_occ <= 2), 1);
         if (o_rden) begin
            chk("credit", ((m_infl + m_occ - int'(mon_xfer)) < 2), 1);
            chk("rd_expected", (addr_q.size() != 0), 1);
            if (addr_q.size() != 0) begin
               mon_a = addr_q.pop_front();
               chk("rdaddr", o_rdaddr, mon_a);
            end
         end
         if (mon_xfer) begin
            chk("word_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("data", o_data, mon_e.d);
               chk("last", o_last, mon_e.l);
            end
            xfer_cnt++;
         end
         m_occ = m_occ + m_infl - int'(mon_xfer);
         m_infl = int'(o_rden);
         stall_prev = o_valid && !i_ready;
         stall_data = o_data;
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] base, input int cnt);
      logic [AW-1:0] a;
      for (int k = 0; k < cnt; k++) begin
         a = base + AW'(k);
         addr_q.push_back(a);
         exp_q.push_back('{d: mem[a], l: (k == cnt - 1)});
      end
   endtask

   task automatic start_burst(input logic [AW-1:0] base, input int cnt);
      push_exp(base, cnt);
      step();
      i_start = 1'b1;
      i_base_addr = base;
      i_count = (AW+1)'(cnt);
      step();
      i_start = 1'b0;
   endtask

   task automatic run_burst(input int budget, input bit rnd);
      int n;
      bit seen;
      n = 0;
      seen = 0;
      while (n < budget && !seen) begin
         step();
         if (rnd) i_ready = 1'($urandom_range(0, 1));
         @(negedge i_clk);
         if (o_done) seen = 1;
         n++;
      end
      chk("done_seen", seen, 1);
      chk("sb_drained", exp_q.size(), 0);
      chk("rd_drained", addr_q.size(), 0);
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("done_pulse", o_done, 0);
      chk("idle_busy", o_busy, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_rden"}, o_rden, 0);
      chk({tag, "_rdaddr"}, o_rdaddr, 0);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_last"}, o_last, 0);
      chk({tag, "_data"}, o_data, 0);
   endtask

   initial begin
      int x0;
      int n;
      for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);

      // reset state
      step();
      chk_all_zero("rst");
      step();
      i_rst = 1'b0;
      step();
      chk_all_zero("post_rst");

      // base 0x010 count 4, cycle-exact latency
      push_exp(10'h010, 4);
      i_start = 1'b1; i_base_addr = 10'h010; i_count = 11'd4;
      step();
      i_start = 1'b0;
      chk("lat_busy", o_busy, 1);
      chk("lat_rden0", o_rden, 1);
      chk("lat_addr0", o_rdaddr, 10'h010);
      chk("lat_valid0", o_valid, 0);
      step();
      chk("lat_rden1", o_rden, 1);
      chk("lat_addr1", o_rdaddr, 10'h011);
      chk("lat_valid1", o_valid, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("lat_valid", o_valid, 1);
         chk("lat_data", o_data, 16'h0010 + 16'(k));
         chk("lat_last", o_last, (k == 3));
         chk("lat_busy_run", o_busy, 1);
      end
      step();
      chk("lat_done", o_done, 1);
      chk("lat_done_busy", o_busy, 0);
      chk("lat_done_valid", o_valid, 0);
      step();
      chk("lat_done_end", o_done, 0);
      chk("lat_sb", exp_q.size(), 0);

      // address wrap
      start_burst(10'h3FE, 4);
      run_burst(40, 0);

      // random back-pressure
      start_burst(10'h080, 8);
      run_burst(300, 1);

      // count 0
      step();
      i_start = 1'b1; i_base_addr = 10'h155; i_count = 11'd0;
      step();
      i_start = 1'b0;
      chk("zero_done", o_done, 1);
      chk("zero_busy", o_busy, 0);
      chk("zero_rden", o_rden, 0);
      chk("zero_valid", o_valid, 0);
      step();
      chk("zero_done_end", o_done, 0);
      chk("zero_rden2", o_rden, 0);

      // second start while busy is ignored
      start_burst(10'h100, 3);
      i_start = 1'b1; i_base_addr = 10'h200; i_count = 11'd5;
      step();
      i_start = 1'b0;
      run_burst(40, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("ign_idle_rden", o_rden, 0);
         chk("ign_idle_valid", o_valid, 0);
      end

      // full address space, wrapping
      start_burst(10'h3F0, 1 << AW);
      run_burst(3000, 0);

      // reset mid-burst
      x0 = xfer_cnt;
      start_burst(10'h040, 6);
      n = 0;
      while (xfer_cnt < x0 + 3 && n < 40) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      chk("abort_reach3", (xfer_cnt >= x0 + 3), 1);
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      addr_q.delete();
      exp_q.delete();
      chk_all_zero("async_rst");
      step();
      step();
      chk_all_zero("hold_rst");
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("abort_no_done", o_done, 0);
         chk("abort_no_busy", o_busy, 0);
         chk("abort_no_valid", o_valid, 0);
      end

      // burst after abort
      start_burst(10'h020, 2);
      run_burst(40, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
